// File: rtl/lock_pkg.sv
// Shared types for the master-PIN change path: the keypad PIN packet, the
// controller state encoding, failure codes and PIN helper functions.
package lock_pkg;

  typedef struct packed {
    logic       status;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] d4;
  } pinPac_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AUTH,
    ST_NEW1,
    ST_NEW2,
    ST_COMMIT,
    ST_WAIT_ACK,
    ST_LOCKOUT
  } state_t;

  localparam logic [1:0] FC_TIMEOUT  = 2'd0;
  localparam logic [1:0] FC_BAD_AUTH = 2'd1;
  localparam logic [1:0] FC_INVALID  = 2'd2;
  localparam logic [1:0] FC_NO_ACK   = 2'd3;

  localparam pinPac_t PIN_BLANK = '{status: 1'b0, d1: 4'hF, d2: 4'hF, d3: 4'hF, d4: 4'hF};

  // A PIN is usable only if every digit is decimal; 4'hF marks an unprogrammed slot.
  function automatic logic pin_valid(pinPac_t p);
    return (p.d1 <= 4'd9) && (p.d2 <= 4'd9) && (p.d3 <= 4'd9) && (p.d4 <= 4'd9);
  endfunction

  function automatic logic pin_eq(pinPac_t a, pinPac_t b);
    return (a.d1 == b.d1) && (a.d2 == b.d2) && (a.d3 == b.d3) && (a.d4 == b.d4);
  endfunction

endpackage

// File: rtl/master_update_ctrl_if.sv
// Bundle between the keypad/admin side, the controller and update_master.
// The slave modport is the controller's view, the master modport its environment's.
interface master_update_ctrl_if;
  import lock_pkg::*;

  logic       admin_req;
  pinPac_t    pin_in;
  pinPac_t    current_master;
  logic       master_ack;
  pinPac_t    upd_pin;
  logic       busy;
  logic       locked;
  logic       update_done;
  logic       update_fail;
  logic [1:0] fail_code;

  modport master (
    output admin_req, pin_in, current_master, master_ack,
    input  upd_pin, busy, locked, update_done, update_fail, fail_code
  );

  modport slave (
    input  admin_req, pin_in, current_master, master_ack,
    output upd_pin, busy, locked, update_done, update_fail, fail_code
  );

endinterface

// File: rtl/cycle_timer.sv
// Free-running cycle counter with a synchronous clear; flags the last cycle
// before the programmable limit is reached.
module cycle_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expire = (r_count == (i_limit - CNT_W'(1)));

endmodule

// File: rtl/master_update_ctrl.sv
// Master-PIN change sequencer: auth, new PIN, confirm, one-cycle commit to
// update_master, ack check, with entry timeouts and auth-failure lockout.
module master_update_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned ACK_WAIT       = 4,
  parameter int unsigned MAX_AUTH_FAIL  = 3,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
  parameter int          CNT_W          = 32
) (
  input logic               clk,
  input logic               rst,
  master_update_ctrl_if.slave bus
);

  localparam int FC_W = $clog2(MAX_AUTH_FAIL + 1);

  state_t           r_state;
  pinPac_t          r_captured;
  pinPac_t          r_updPin;
  logic [FC_W-1:0]  r_authFails;
  logic             r_busy;
  logic             r_locked;
  logic             r_done;
  logic             r_fail;
  logic [1:0]       r_failCode;

  logic [FC_W-1:0]  w_failsNext;
  logic [CNT_W-1:0] w_limit;
  logic             w_clear;
  logic             w_expire;

  assign w_failsNext = r_authFails + FC_W'(1);

  always_comb begin
    w_limit = CNT_W'(TIMEOUT_CYCLES);
    if (r_state == ST_WAIT_ACK) begin
      w_limit = CNT_W'(ACK_WAIT);
    end else if (r_state == ST_LOCKOUT) begin
      w_limit = CNT_W'(LOCKOUT_CYCLES);
    end
  end

  // The timer is held at zero outside timed states and restarted on every
  // event that leaves one, so each timed state starts counting from 0.
  always_comb begin
    w_clear = w_expire;
    case (r_state)
      ST_AUTH, ST_NEW1, ST_NEW2: if (bus.pin_in.status) w_clear = 1'b1;
      ST_WAIT_ACK:               if (bus.master_ack)    w_clear = 1'b1;
      ST_LOCKOUT:                ;
      default:                   w_clear = 1'b1;
    endcase
  end

  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_limit  (w_limit),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_captured  <= PIN_BLANK;
      r_updPin    <= PIN_BLANK;
      r_authFails <= '0;
      r_busy      <= 1'b0;
      r_locked    <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_failCode  <= FC_TIMEOUT;
    end else begin
      r_updPin.status <= 1'b0;
      r_done          <= 1'b0;
      r_fail          <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.admin_req) begin
            r_busy  <= 1'b1;
            r_state <= pin_valid(bus.current_master) ? ST_AUTH : ST_NEW1;
          end
        end

        ST_AUTH: begin
          if (bus.pin_in.status) begin
            if (pin_eq(bus.pin_in, bus.current_master)) begin
              r_authFails <= '0;
              r_state     <= ST_NEW1;
            end else begin
              r_authFails <= w_failsNext;
              r_fail      <= 1'b1;
              r_failCode  <= FC_BAD_AUTH;
              if (w_failsNext == FC_W'(MAX_AUTH_FAIL)) begin
                r_locked <= 1'b1;
                r_state  <= ST_LOCKOUT;
              end else begin
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end
          end else if (w_expire) begin
            r_fail     <= 1'b1;
            r_failCode <= FC_TIMEOUT;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        ST_NEW1: begin
          if (bus.pin_in.status) begin
            if (pin_valid(bus.pin_in)) begin
              r_captured <= {1'b0, bus.pin_in[15:0]};
              r_state    <= ST_NEW2;
            end else begin
              r_fail     <= 1'b1;
              r_failCode <= FC_INVALID;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end else if (w_expire) begin
            r_fail     <= 1'b1;
            r_failCode <= FC_TIMEOUT;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        // The commit word is loaded here so upd_pin carries it during COMMIT only.
        ST_NEW2: begin
          if (bus.pin_in.status) begin
            if (pin_eq(bus.pin_in, r_captured)) begin
              r_updPin <= {1'b1, r_captured[15:0]};
              r_state  <= ST_COMMIT;
            end else begin
              r_captured <= PIN_BLANK;
              r_fail     <= 1'b1;
              r_failCode <= FC_INVALID;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end else if (w_expire) begin
            r_fail     <= 1'b1;
            r_failCode <= FC_TIMEOUT;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        ST_COMMIT: begin
          r_state <= ST_WAIT_ACK;
        end

        ST_WAIT_ACK: begin
          if (bus.master_ack) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_expire) begin
            r_fail     <= 1'b1;
            r_failCode <= FC_NO_ACK;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        ST_LOCKOUT: begin
          if (w_expire) begin
            r_authFails <= '0;
            r_locked    <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_locked <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.upd_pin     = r_updPin;
  assign bus.busy        = r_busy;
  assign bus.locked      = r_locked;
  assign bus.update_done = r_done;
  assign bus.update_fail = r_fail;
  assign bus.fail_code   = r_failCode;

endmodule
